// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

    localparam int unsigned MUL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : shift_add_multiplier_pkg

// File: rtl/Ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder used as the add stage.
module Ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[4];

endmodule : Ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per cycle via shift-and-add.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // The add stage is a fixed 4-bit adder, so no other operand width can work.
    if (WIDTH != MUL_WIDTH) begin : g_bad_width
        $error("shift_add_multiplier: WIDTH must be %0d", MUL_WIDTH);
    end

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [WIDTH-1:0]     r_mcand;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_next_acc;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_addend   = r_acc_lo[0] ? r_mcand : '0;
    assign w_next_acc = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

    Ripple_carry_adder u_add (
        .a    (r_acc_hi),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Control FSM, iteration counter and accumulator shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_mcand  <= a;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_next_acc;
                    r_cnt                <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_product <= w_next_acc;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: latency model plus directed cases.
module tb_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model: an accepted request completes 4 cycles later with a*b.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_prod = '0;
    logic [7:0] m_pend = '0;

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= {4'b0, a} * {4'b0, b};
                m_left <= 4;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy",    32'(busy),    32'(m_left > 0));
            chk("model_done",    32'(done),    32'(m_done));
            chk("model_product", 32'(product), 32'(m_prod));
        end
    end

    // Start one operation and wait (bounded) for its done pulse.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp, input string name);
        int n;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; a = 4'hA; b = 4'h5; end
            if (done) begin n = i; break; end
        end
        chk({name, "_latency"}, 32'(n), 32'd5);
        chk({name, "_product"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int n;
        int dones;
        // Reset then idle
        rst_n = 1'b0;
        @(posedge clk); #1 cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_product", 32'(product), 32'd0);
        chk("idle_busy",    32'(busy),    32'd0);
        chk("idle_done",    32'(done),    32'd0);

        run_op(4'd3,  4'd5,  8'd15,  "mul_3x5");
        repeat (3) @(negedge clk);
        chk("hold_product", 32'(product), 32'd15);
        chk("hold_busy",    32'(busy),    32'd0);
        run_op(4'd15, 4'd15, 8'd225, "mul_15x15");
        run_op(4'd7,  4'd8,  8'd56,  "mul_7x8");
        run_op(4'd0,  4'd9,  8'd0,   "mul_0x9");
        run_op(4'd15, 4'd1,  8'd15,  "mul_15x1");

        // Start during RUN is ignored
        @(negedge clk);
        a = 4'd2; b = 4'd3; start = 1'b1;
        n = 0; dones = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin start = 1'b1; a = 4'd9; b = 4'd9; end
            if (i == 3) start = 1'b0;
            if (i <= 4) chk("ign_busy", 32'(busy), 32'd1);
            if (done) begin
                dones++;
                if (n == 0) n = i;
            end
        end
        chk("ign_latency", 32'(n), 32'd5);
        chk("ign_dones",   32'(dones), 32'd1);
        chk("ign_product", 32'(product), 32'd6);

        // Back-to-back with start held high
        @(negedge clk);
        a = 4'd4; b = 4'd4; start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin a = 4'd5; b = 4'd6; end
            if (i == 6) start = 1'b0;
            if (i == 5) begin
                chk("b2b_done1", 32'(done), 32'd1);
                chk("b2b_prod1", 32'(product), 32'd16);
            end
            if (i == 10) begin
                chk("b2b_done2", 32'(done), 32'd1);
                chk("b2b_prod2", 32'(product), 32'd30);
            end
            if (i != 5 && i != 10) chk("b2b_busy", 32'(busy), 32'd1);
            if (done) dones++;
        end
        chk("b2b_dones", 32'(dones), 32'd2);
        start = 1'b0;

        // Reset in the middle of an operation
        @(negedge clk);
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("abort_busy",    32'(busy),    32'd0);
        chk("abort_product", 32'(product), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_op(4'd3, 4'd5, 8'd15, "post_abort");

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; a = 4'd7; b = 4'd7;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        chk("rst_start_busy",    32'(busy),    32'd0);
        chk("rst_start_product", 32'(product), 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_start_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 4x4 unsigned multiplier built around the team's `Ripple_carry_adder`.
- It is the stage directly upstream of the adder: it sequences operands into the adder once per cycle and consumes its sum and carry-out.
- Uses the shift-and-add method, one multiplier bit per cycle.
- Presents an 8-bit product with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width. Fixed at 4 because the instantiated `Ripple_carry_adder` is 4-bit. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand, captured on the accepting edge
- b  input  WIDTH  multiplier, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  registered result, held until the next completion

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc_hi, acc_lo, mcand and cnt are all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 loads acc_hi=0, acc_lo=b, mcand=a, cnt=0, and moves to RUN. start=0 stays in IDLE.
  - RUN, each edge:
    - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), cin=0.
    - Update {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]}.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: product <= the new {acc_hi, acc_lo} and state moves to DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back operation) and moves to RUN.
    - Otherwise the next state is IDLE.
- Latency:
  - start accepted at E0; done is high in the cycle after edge E0+WIDTH (4 cycles after acceptance).
  - Throughput: one result every WIDTH+1 cycles in back-to-back mode.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- start while busy is ignored; no queueing, and the operation in flight is unaffected.
- a and b may change freely after the accepting edge.
- Width rules:
  - Unsigned only. The carry-out is folded into acc_hi each step, so no overflow is possible.
  - Maximum result is 15*15=225 (8'hE1).
  - cnt is $clog2(WIDTH+1) bits wide and never wraps within an operation.
- product changes only on the edge entering DONE (or on reset). Between operations it holds the last result.
- Reset mid-RUN:
  - The next edge with rst_n=0 aborts the operation and clears product.
  - done is never asserted for the aborted operation.
- Reset asserted on the same edge as start: reset wins and start is ignored.
- Zero operands need no special path: all WIDTH iterations still run.

Decomposition:
- Shared package/header: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; constant MUL_WIDTH=4.
- Sub-module: a single instance of the existing `Ripple_carry_adder` (ports a, b, cin, sum, cout) as the add stage. Do not re-implement the adder.
- Control FSM, counter and shift register stay in shift_add_multiplier (roughly 120-180 lines).

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, start=0 -> product=0, busy=0, done=0 throughout.
- Basic: a=3, b=5, start pulse -> busy=1 for 4 cycles, then done=1 for one cycle with product=8'd15, then IDLE with product held at 15.
- Carry/extremes:
  - a=15, b=15 -> product=8'd225.
  - a=7, b=8 -> 56.
  - a=0, b=9 -> 0.
  - a=15, b=1 -> 15.
- Ignored start: begin a=2, b=3; pulse start with a=9, b=9 on the second RUN cycle -> product=6, done pulses once, busy timing unchanged.
- Back-to-back: hold start=1 with a=4, b=4 and then a=5, b=6 -> done pulses 5 cycles apart with products 16 then 30; IDLE is never visited.
- Reset mid-operation: a=15, b=15 started; rst_n=0 on the 2nd RUN cycle -> product=0, busy=0, no done pulse. A fresh a=3, b=5 afterwards -> 15.
